fixed_point_sqrt_arbiter: RTL and testbench
===========================================

Name: fixed_point_sqrt_arbiter

Overview:
- Shares one FixedPointSquareRoot instance (registered, 1-cycle latency, no back-pressure) between N requesters, for example vector-normalise and ray-length units.
- Performs round-robin arbitration and issues at most one operation per cycle.
- Carries a requester tag through the sqrt latency and returns each result into a per-requester holding register.
- Each result is held until that requester acknowledges it.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- SQRT_LATENCY, 1: cycles from oSqrtInputReady to iSqrtOutputReady; equals the FFDelay depth of the sqrt unit.
- TAG_W, 2: tag width; must satisfy 2**TAG_W >= NUM_REQ.

Ports:
- Clock, in, 1: single clock, rising edge.
- Reset, in, 1: synchronous, active-high. Shared with the sqrt instance.
- iRequest, in, NUM_REQ: level request. Held with its operand until the matching oGrant bit pulses.
- iOperand, in, NUM_REQ*`LONG_WIDTH: packed operands; slice k belongs to requester k.
- oGrant, out, NUM_REQ: one-hot, one-cycle pulse.
- oSqrtOperand, out, `LONG_WIDTH: registered operand to the sqrt unit.
- oSqrtInputReady, out, 1: registered issue strobe to the sqrt unit.
- iSqrtOutputReady, in, 1: sqrt OutputReady.
- iSqrtResult, in, `WIDTH: sqrt Result, fixed point `SCALE.
- oResult, out, NUM_REQ*`WIDTH: per-requester held results.
- oResultValid, out, NUM_REQ: sticky; set when a result lands, cleared by ack.
- iResultAck, in, NUM_REQ: one-cycle ack per requester.
- oProtocolError, out, 1: sticky; cleared only by Reset.

Behaviour:
- Reset values:
  - oGrant, oSqrtInputReady, oResultValid, oProtocolError are 0.
  - oSqrtOperand and oResult are all 0.
  - Round-robin pointer is 0; all inflight bits, pending bits and tag pipe valids are 0.
  - Reset asserted mid-operation drops all in-flight and held results. The sqrt unit shares Reset, so no stale OutputReady can arrive.
- Eligibility: elig[k] = iRequest[k] & ~inflight[k] & ~oResultValid[k]. Each requester has at most one operation outstanding.
- Arbitration (combinational, on registered state):
  - Choose the first eligible k, searching from ptr upward and wrapping modulo NUM_REQ.
  - No eligible requester means no issue that cycle.
- On the clock edge when requester k wins:
  - oGrant[k] <= 1 and oSqrtInputReady <= 1.
  - oSqrtOperand <= iOperand slice k.
  - inflight[k] <= 1.
  - ptr <= (k+1) mod NUM_REQ.
  - Tag pipe stage 0 <= {valid=1, tag=k}.
- When no requester wins, oGrant and oSqrtInputReady are 0 the next cycle; oSqrtOperand holds its value.
- Tag pipe:
  - A shift register of SQRT_LATENCY stages (valid + tag), advanced every cycle.
  - Its last stage is aligned with iSqrtOutputReady.
- On iSqrtOutputReady with a valid last stage, tag t:
  - oResult slice t <= iSqrtResult.
  - oResultValid[t] <= 1 and inflight[t] <= 0.
- On iSqrtOutputReady with an invalid last stage: set oProtocolError and discard the result.
- On a valid last stage without iSqrtOutputReady: set oProtocolError and clear inflight[t], so the requester is not deadlocked.
- Latency and throughput (SQRT_LATENCY=1):
  - Request seen in cycle c → oGrant and issue in c+1 → sqrt result in c+2 → oResultValid in c+3.
  - Sustained throughput is one issue per cycle across distinct requesters.
- Ack:
  - iResultAck[k] clears oResultValid[k] on the next edge; oResult slice k keeps its last value.
  - An ack with valid=0 is ignored.
  - Ack and a new result for the same k cannot coincide, because eligibility requires valid=0.
  - k becomes eligible again in the cycle after the ack edge.
- Widths: results pass through unmodified. Operands of 128.0 and above are handled inside the sqrt unit, so the arbiter does no range checks.

Decomposition:
- Use `WIDTH, `LONG_WIDTH and `SCALE from aDefinitions.v.
- Add to the shared definitions: `SQRT_NUM_REQ, `SQRT_TAG_W.
- Build all registers from FFD_POSEDGE_SYNCRONOUS_RESET instances.
- One natural sub-module: round_robin_picker (inputs elig and ptr; outputs one-hot win and win_index), purely combinational and reusable by other shared-unit arbiters.

Test Plan:
- Single request, requester 0, operand 64'h0000_0000_0020_0000 (16.0):
  - oGrant[0] pulses 1 cycle later.
  - oResultValid[0] rises 3 cycles after the request, with oResult[0] = 32'h80000 (4.0).
  - Ack clears valid.
- All four requesting from reset, with operands 4.0/9.0/36.0/100.0:
  - Grants in order 0,1,2,3 on consecutive cycles.
  - Results 32'h40000, 32'h60000, 32'hC0000, 32'h140000.
- Requester 2 holds its request without acking:
  - No second grant to 2 while oResultValid[2]=1.
  - Other requesters continue to win; 2 is granted the cycle after its ack.
- Fairness: requesters 1 and 3 held continuously with immediate acks → grants alternate 1,3,1,3 and neither starves.
- Reset asserted in the cycle after a grant:
  - All outputs return to 0 the next cycle and no result lands.
  - A fresh request afterwards completes normally.
- iSqrtOutputReady forced high with an empty tag pipe → oProtocolError=1 and no oResultValid change; error stays set until Reset.

Source files
------------

// File: rtl/fixed_point_sqrt_arbiter_pkg.sv
// Shared definitions for the square-root arbiter: fixed-point widths and
// default requester count / tag width.
package fixed_point_sqrt_arbiter_pkg;

  localparam int WIDTH        = 32;
  localparam int LONG_WIDTH   = 64;
  localparam int SCALE        = 17;
  localparam int SQRT_NUM_REQ = 4;
  localparam int SQRT_TAG_W   = 2;

  typedef logic [WIDTH-1:0]      sqrtResult_t;
  typedef logic [LONG_WIDTH-1:0] sqrtOperand_t;

endpackage

// File: rtl/fixed_point_sqrt_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first set bit of elig at or after ptr,
// wrapping modulo N. Reusable by any shared-unit arbiter.
module round_robin_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] winIndex,
  output logic             anyWin
);

  logic [IDX_W-1:0] idx;

  // Rotating priority search starting at ptr
  always_comb begin
    win      = {N{1'b0}};
    winIndex = {IDX_W{1'b0}};
    anyWin   = 1'b0;
    idx      = ptr;
    for (int i = 0; i < N; i++) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (!anyWin && elig[idx]) begin
        win[idx] = 1'b1;
        winIndex = idx;
        anyWin   = 1'b1;
      end else begin
        anyWin = anyWin;
      end
    end
  end

endmodule

// File: rtl/fixed_point_sqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point square-root unit
// among NUM_REQ requesters, with tagged return into per-requester holding registers.
module fixed_point_sqrt_arbiter
  import fixed_point_sqrt_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = SQRT_NUM_REQ,
  parameter int SQRT_LATENCY = 1,
  parameter int TAG_W        = SQRT_TAG_W
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          iRequest,
  input  logic [NUM_REQ*LONG_WIDTH-1:0] iOperand,
  output logic [NUM_REQ-1:0]          oGrant,
  output logic [LONG_WIDTH-1:0]       oSqrtOperand,
  output logic                        oSqrtInputReady,
  input  logic                        iSqrtOutputReady,
  input  logic [WIDTH-1:0]            iSqrtResult,
  output logic [NUM_REQ*WIDTH-1:0]    oResult,
  output logic [NUM_REQ-1:0]          oResultValid,
  input  logic [NUM_REQ-1:0]          iResultAck,
  output logic                        oProtocolError
);

  logic [NUM_REQ-1:0]       inflight;
  logic [NUM_REQ-1:0]       elig;
  logic [NUM_REQ-1:0]       win;
  logic [TAG_W-1:0]         winIndex;
  logic                     anyWin;
  logic [TAG_W-1:0]         ptr;
  logic [TAG_W-1:0]         ptrNext;
  logic [TAG_W-1:0]         issueTag;
  sqrtOperand_t             opSel;

  logic                     pipeValid [SQRT_LATENCY];
  logic [TAG_W-1:0]         pipeTag   [SQRT_LATENCY];
  logic                     lastValid;
  logic [TAG_W-1:0]         lastTag;

  logic [NUM_REQ-1:0]       lastOneHot;
  logic [NUM_REQ-1:0]       landMask;
  logic [NUM_REQ-1:0]       inflightNext;
  logic [NUM_REQ-1:0]       validNext;
  logic [NUM_REQ*WIDTH-1:0] resultNext;
  logic                     errorNext;

  assign lastValid = pipeValid[SQRT_LATENCY-1];
  assign lastTag   = pipeTag[SQRT_LATENCY-1];

  // One outstanding operation per requester: busy from grant until ack
  always_comb begin
    elig = iRequest & ~inflight & ~oResultValid;
  end

  round_robin_picker #(
    .N     (NUM_REQ),
    .IDX_W (TAG_W)
  ) uPicker (
    .elig     (elig),
    .ptr      (ptr),
    .win      (win),
    .winIndex (winIndex),
    .anyWin   (anyWin)
  );

  // One-hot operand mux driven by the winner vector
  always_comb begin
    opSel = {LONG_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      opSel = opSel | ({LONG_WIDTH{win[k]}} & iOperand[k*LONG_WIDTH +: LONG_WIDTH]);
    end
  end

  // Pointer moves just past the winner; unchanged when idle
  always_comb begin
    if (!anyWin) begin
      ptrNext = ptr;
    end else if (winIndex == TAG_W'(NUM_REQ - 1)) begin
      ptrNext = {TAG_W{1'b0}};
    end else begin
      ptrNext = winIndex + TAG_W'(1);
    end
  end

  // Result landing, ack clearing and protocol checking against the tag pipe
  always_comb begin
    lastOneHot = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      lastOneHot[k] = lastValid && (lastTag == TAG_W'(k));
    end
    landMask = lastOneHot & {NUM_REQ{iSqrtOutputReady}};
    // A valid tag always retires its inflight bit, even if the result never came
    inflightNext = (inflight | win) & ~lastOneHot;
    validNext    = (oResultValid & ~iResultAck) | landMask;
    errorNext    = oProtocolError | (iSqrtOutputReady ^ lastValid);
    resultNext   = oResult;
    for (int k = 0; k < NUM_REQ; k++) begin
      resultNext[k*WIDTH +: WIDTH] = landMask[k] ? iSqrtResult : oResult[k*WIDTH +: WIDTH];
    end
  end

  // Issue stage: grant pulse, operand and strobe towards the sqrt unit
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oGrant          <= {NUM_REQ{1'b0}};
      oSqrtInputReady <= 1'b0;
      oSqrtOperand    <= {LONG_WIDTH{1'b0}};
      issueTag        <= {TAG_W{1'b0}};
      ptr             <= {TAG_W{1'b0}};
    end else begin
      oGrant          <= win;
      oSqrtInputReady <= anyWin;
      oSqrtOperand    <= anyWin ? opSel : oSqrtOperand;
      issueTag        <= winIndex;
      ptr             <= ptrNext;
    end
  end

  // Tag pipe: stage 0 follows the issue strobe, last stage meets OutputReady
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < SQRT_LATENCY; i++) begin
        pipeValid[i] <= 1'b0;
        pipeTag[i]   <= {TAG_W{1'b0}};
      end
    end else begin
      pipeValid[0] <= oSqrtInputReady;
      pipeTag[0]   <= issueTag;
      for (int i = 1; i < SQRT_LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeTag[i]   <= pipeTag[i-1];
      end
    end
  end

  // Per-requester bookkeeping, held results and sticky error
  always_ff @(posedge Clock) begin
    if (Reset) begin
      inflight       <= {NUM_REQ{1'b0}};
      oResultValid   <= {NUM_REQ{1'b0}};
      oResult        <= {(NUM_REQ*WIDTH){1'b0}};
      oProtocolError <= 1'b0;
    end else begin
      inflight       <= inflightNext;
      oResultValid   <= validNext;
      oResult        <= resultNext;
      oProtocolError <= errorNext;
    end
  end

endmodule

// File: tb/tb_fixed_point_sqrt_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, checked against a
// transaction-level model (outstanding-until-ack, rotating priority, fixed latency).
module tb_fixed_point_sqrt_arbiter;
  import fixed_point_sqrt_arbiter_pkg::*;

  localparam int N = 4;

  logic            Clock;
  logic            Reset;
  logic [N-1:0]    iRequest;
  logic [N*64-1:0] iOperand;
  logic [N-1:0]    oGrant;
  logic [63:0]     oSqrtOperand;
  logic            oSqrtInputReady;
  logic            sqrtReady;
  logic [31:0]     sqrtResult;
  logic [N*32-1:0] oResult;
  logic [N-1:0]    oResultValid;
  logic [N-1:0]    iResultAck;
  logic            oProtocolError;
  logic            forceRdy;

  int checks = 0;
  int errors = 0;

  // model state
  int          mPtr;
  bit          mBusy    [N];
  int          mLand    [N];
  logic [31:0] mLandVal [N];
  logic [31:0] mResult  [N];
  logic [N-1:0] mValid;
  logic [N-1:0] mGrant;
  logic        mIssue;
  logic [63:0] mOperand;
  logic        mError;

  int g1, g3, g2count, lastG, altBad;

  fixed_point_sqrt_arbiter dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .iRequest         (iRequest),
    .iOperand         (iOperand),
    .oGrant           (oGrant),
    .oSqrtOperand     (oSqrtOperand),
    .oSqrtInputReady  (oSqrtInputReady),
    .iSqrtOutputReady (sqrtReady),
    .iSqrtResult      (sqrtResult),
    .oResult          (oResult),
    .oResultValid     (oResultValid),
    .iResultAck       (iResultAck),
    .oProtocolError   (oProtocolError)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [31:0] sqrtRef(input logic [63:0] op);
    logic [127:0] x, res, cand;
    x   = {64'h0, op} << SCALE;
    res = 128'h0;
    for (int b = 63; b >= 0; b--) begin
      cand = res | (128'h1 << b);
      if (cand * cand <= x) res = cand;
    end
    return res[31:0];
  endfunction

  // Stand-in for the sqrt unit: registered, one-cycle latency, shares Reset
  always @(posedge Clock) begin
    if (Reset) begin
      sqrtReady  <= 1'b0;
      sqrtResult <= 32'h0;
    end else begin
      sqrtReady  <= oSqrtInputReady | forceRdy;
      sqrtResult <= sqrtRef(oSqrtOperand);
    end
  end

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPtr = 0; mValid = '0; mGrant = '0; mIssue = 1'b0; mOperand = 64'h0; mError = 1'b0;
    for (int k = 0; k < N; k++) begin
      mBusy[k] = 1'b0; mLand[k] = 0; mLandVal[k] = 32'h0; mResult[k] = 32'h0;
    end
  endtask

  // Advance one clock: update model from the driven inputs, then compare
  task automatic step();
    int w;
    w = -1;
    if (Reset) begin
      modelReset();
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (mPtr + i) % N;
        if (w < 0 && iRequest[k] && !mBusy[k]) w = k;
      end
      for (int k = 0; k < N; k++) begin
        if (iResultAck[k] && mValid[k]) begin
          mValid[k] = 1'b0;
          mBusy[k]  = 1'b0;
        end
        if (mLand[k] > 0) begin
          mLand[k]--;
          if (mLand[k] == 0) begin
            mValid[k]  = 1'b1;
            mResult[k] = mLandVal[k];
          end
        end
      end
      mGrant = '0;
      mIssue = 1'b0;
      if (w >= 0) begin
        mGrant[w]   = 1'b1;
        mIssue      = 1'b1;
        mOperand    = iOperand[w*64 +: 64];
        mBusy[w]    = 1'b1;
        mLand[w]    = 2;
        mLandVal[w] = sqrtRef(mOperand);
        mPtr        = (w + 1) % N;
      end
    end
    @(posedge Clock);
    @(negedge Clock);
    checkValue("grant", 64'(oGrant), 64'(mGrant));
    checkValue("issue", 64'(oSqrtInputReady), 64'(mIssue));
    checkValue("operand", oSqrtOperand, mOperand);
    checkValue("valid", 64'(oResultValid), 64'(mValid));
    checkValue("error", 64'(oProtocolError), 64'(mError));
    for (int k = 0; k < N; k++) begin
      checkValue("result", 64'(oResult[k*32 +: 32]), 64'(mResult[k]));
    end
  endtask

  task automatic doReset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; iRequest = '0; iOperand = '0; iResultAck = '0; forceRdy = 1'b0;
    modelReset();
    step();
    step();
    Reset = 1'b0;

    // single request: 16.0 -> 4.0
    iOperand[63:0] = 64'h0000_0000_0020_0000;
    iRequest = 4'b0001;
    step();
    checkValue("single_grant", 64'(oGrant), 64'h1);
    iRequest = 4'b0000;
    step();
    step();
    checkValue("single_valid", 64'(oResultValid[0]), 64'h1);
    checkValue("single_result", 64'(oResult[31:0]), 64'h80000);
    iResultAck = 4'b0001;
    step();
    iResultAck = 4'b0000;
    checkValue("single_ack", 64'(oResultValid[0]), 64'h0);

    // all four from reset
    doReset();
    iOperand = {64'h0000_0000_00C8_0000, 64'h0000_0000_0048_0000,
                64'h0000_0000_0012_0000, 64'h0000_0000_0008_0000};
    iRequest = 4'b1111;
    for (int i = 0; i < N; i++) begin
      step();
      checkValue("order_grant", 64'(oGrant), 64'(4'b0001 << i));
      iRequest = iRequest & ~mGrant;
    end
    step();
    step();
    checkValue("four_r0", 64'(oResult[31:0]),   64'h40000);
    checkValue("four_r1", 64'(oResult[63:32]),  64'h60000);
    checkValue("four_r2", 64'(oResult[95:64]),  64'hC0000);
    checkValue("four_r3", 64'(oResult[127:96]), 64'h140000);
    iResultAck = 4'b1111;
    step();
    iResultAck = 4'b0000;

    // requester 2 held without ack while others keep winning
    doReset();
    g2count = 0;
    iRequest = 4'b0100;
    iOperand[2*64 +: 64] = 64'h0000_0000_0004_0000;
    for (int c = 0; c < 14; c++) begin
      for (int k = 0; k < N; k++) begin
        if (k != 2) begin
          if (mGrant[k] || !iRequest[k]) begin
            iRequest[k] = ($urandom_range(0, 1) == 1);
            iOperand[k*64 +: 64] = {32'h0, $urandom};
          end
          iResultAck[k] = mValid[k];
        end
      end
      step();
      if (oGrant[2]) g2count++;
    end
    checkValue("hold2_single_grant", 64'(g2count), 64'h1);
    iResultAck = 4'b0100;
    step();
    iResultAck = 4'b0000;
    iRequest = 4'b0100;
    step();
    checkValue("hold2_regrant", 64'(oGrant), 64'h4);
    iRequest = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      iResultAck = mValid;
      step();
    end
    iResultAck = 4'b0000;

    // fairness between 1 and 3 with immediate acks
    doReset();
    g1 = 0; g3 = 0; lastG = -1; altBad = 0;
    iOperand[1*64 +: 64] = 64'h0000_0000_0012_0000;
    iOperand[3*64 +: 64] = 64'h0000_0000_0048_0000;
    iRequest = 4'b1010;
    for (int c = 0; c < 24; c++) begin
      iResultAck = mValid;
      step();
      if (oGrant[1]) begin if (lastG == 1) altBad++; lastG = 1; g1++; end
      if (oGrant[3]) begin if (lastG == 3) altBad++; lastG = 3; g3++; end
    end
    iRequest = 4'b0000;
    checkValue("fair_alternate", 64'(altBad), 64'h0);
    checkValue("fair_g1", 64'(g1 >= 5), 64'h1);
    checkValue("fair_g3", 64'(g3 >= 5), 64'h1);
    for (int c = 0; c < 4; c++) begin
      iResultAck = mValid;
      step();
    end
    iResultAck = 4'b0000;

    // reset in the cycle after a grant
    iOperand[63:0] = 64'h0000_0000_0020_0000;
    iRequest = 4'b0001;
    step();
    iRequest = 4'b0000;
    doReset();
    checkValue("rst_valid", 64'(oResultValid), 64'h0);
    step();
    step();
    step();
    checkValue("rst_nolanding", 64'(oResultValid), 64'h0);
    iRequest = 4'b0001;
    step();
    iRequest = 4'b0000;
    step();
    step();
    checkValue("rst_fresh", 64'(oResult[31:0]), 64'h80000);
    iResultAck = 4'b0001;
    step();
    iResultAck = 4'b0000;

    // OutputReady with empty tag pipe
    step();
    forceRdy = 1'b1;
    step();
    forceRdy = 1'b0;
    mError = 1'b1;
    step();
    checkValue("proto_err", 64'(oProtocolError), 64'h1);
    for (int c = 0; c < 3; c++) step();
    checkValue("proto_sticky", 64'(oProtocolError), 64'h1);
    doReset();
    checkValue("proto_clear", 64'(oProtocolError), 64'h0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      Reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (mGrant[k] || !iRequest[k]) begin
          iRequest[k] = ($urandom_range(0, 1) == 1);
          iOperand[k*64 +: 64] = {32'h0, $urandom};
        end
        iResultAck[k] = mValid[k] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      end
      step();
    end
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
